// File: rtl/alu_result_drain_if.sv
// ---------------------------------------------------------------------------
// alu_result_drain_if
// Groups the two handshakes around the ALU result drain:
//   ALU side : in_valid / in_ready / op_code / alu_out (64-bit result)
//   bus side : bus_out / bus_valid / bus_ready / bus_is_hi (32-bit beats)
// Modports:
//   master : the environment (ALU producer plus bus sink)
//   slave  : the drain block itself
// ---------------------------------------------------------------------------
interface alu_result_drain_if #(
    parameter int DATA_W = 32
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            op_code;
    logic [2*DATA_W-1:0]   alu_out;
    logic [DATA_W-1:0]     bus_out;
    logic                  bus_valid;
    logic                  bus_ready;
    logic                  bus_is_hi;

    modport master (
        output in_valid,
        output op_code,
        output alu_out,
        output bus_ready,
        input  in_ready,
        input  bus_out,
        input  bus_valid,
        input  bus_is_hi
    );

    modport slave (
        input  in_valid,
        input  op_code,
        input  alu_out,
        input  bus_ready,
        output in_ready,
        output bus_out,
        output bus_valid,
        output bus_is_hi
    );

endinterface

// File: rtl/alu_result_drain.sv
// ---------------------------------------------------------------------------
// alu_result_drain
// Consumer end of the ALU output. Captures the 2*DATA_W ALU result into the
// Z register pair (z_hi / z_lo) and drains it onto the DATA_W-wide bus as
// one beat (LO only) or, for multiply/divide, two beats (LO then HI) under a
// valid/ready handshake.
//
// Ports:
//   clock        rising-edge clock
//   clear        synchronous active-high reset, highest priority
//   io           slave side of alu_result_drain_if (ALU and bus handshakes)
//   z_lo, z_hi   captured Z register pair
//   lo_we, hi_we one-cycle pulses following a write of ZLO / ZHI
//   result_count number of fully drained results (wraps)
// ---------------------------------------------------------------------------
module alu_result_drain #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    alu_result_drain_if.slave     io,
    output logic [DATA_W-1:0]     z_lo,
    output logic [DATA_W-1:0]     z_hi,
    output logic                  lo_we,
    output logic                  hi_we,
    output logic [CNT_W-1:0]      result_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;

    // Multiply and divide are the only ops with a meaningful HI word on the bus.
    function automatic logic is_wide_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic                wide_r;
    logic                wide_s;
    logic [DATA_W-1:0]   z_lo_r;
    logic [DATA_W-1:0]   z_hi_r;
    logic                capture_s;
    logic [DATA_W-1:0]   bus_out_r;
    logic [DATA_W-1:0]   bus_out_s;
    logic                bus_valid_r;
    logic                bus_valid_s;
    logic                bus_is_hi_r;
    logic                bus_is_hi_s;
    logic                lo_we_r;
    logic                lo_we_s;
    logic                hi_we_r;
    logic                hi_we_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_s;

    // State register; clear returns to IDLE ahead of any transition.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output decode. Outputs are computed one cycle ahead
    // so that every bus-side output comes straight from a flop.
    always_comb begin
        state_s     = state_r;
        wide_s      = wide_r;
        capture_s   = 1'b0;
        bus_out_s   = bus_out_r;
        bus_valid_s = bus_valid_r;
        bus_is_hi_s = bus_is_hi_r;
        lo_we_s     = 1'b0;
        hi_we_s     = 1'b0;
        count_s     = count_r;

        case (state_r)
            ST_IDLE: begin
                if (io.in_valid) begin
                    // The first beat is always the LO word, taken directly
                    // from the ALU so it is valid the cycle after capture.
                    capture_s   = 1'b1;
                    wide_s      = is_wide_op(io.op_code);
                    state_s     = ST_LO;
                    bus_out_s   = io.alu_out[DATA_W-1:0];
                    bus_valid_s = 1'b1;
                    bus_is_hi_s = 1'b0;
                    lo_we_s     = 1'b1;
                    hi_we_s     = is_wide_op(io.op_code);
                end else begin
                    bus_valid_s = 1'b0;
                    bus_is_hi_s = 1'b0;
                end
            end

            ST_LO: begin
                if (io.bus_ready) begin
                    if (wide_r) begin
                        state_s     = ST_HI;
                        bus_out_s   = z_hi_r;
                        bus_valid_s = 1'b1;
                        bus_is_hi_s = 1'b1;
                    end else begin
                        state_s     = ST_IDLE;
                        bus_valid_s = 1'b0;
                        bus_is_hi_s = 1'b0;
                        count_s     = count_r + CNT_W'(1);
                    end
                end else begin
                    // Backpressure: hold the LO beat unchanged.
                    state_s = ST_LO;
                end
            end

            ST_HI: begin
                if (io.bus_ready) begin
                    state_s     = ST_IDLE;
                    bus_valid_s = 1'b0;
                    bus_is_hi_s = 1'b0;
                    count_s     = count_r + CNT_W'(1);
                end else begin
                    // Backpressure: hold the HI beat unchanged.
                    state_s = ST_HI;
                end
            end

            default: begin
                // Unreachable encoding: recover to IDLE with the bus quiet.
                state_s     = ST_IDLE;
                bus_valid_s = 1'b0;
                bus_is_hi_s = 1'b0;
            end
        endcase
    end

    // Z register pair and output flops; clear discards any result in flight.
    always_ff @(posedge clock) begin
        if (clear) begin
            wide_r      <= 1'b0;
            z_lo_r      <= {DATA_W{1'b0}};
            z_hi_r      <= {DATA_W{1'b0}};
            bus_out_r   <= {DATA_W{1'b0}};
            bus_valid_r <= 1'b0;
            bus_is_hi_r <= 1'b0;
            lo_we_r     <= 1'b0;
            hi_we_r     <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
        end else begin
            if (capture_s) begin
                // ZHI is captured for every op, even when it never reaches the bus.
                z_lo_r <= io.alu_out[DATA_W-1:0];
                z_hi_r <= io.alu_out[2*DATA_W-1:DATA_W];
            end else begin
                z_lo_r <= z_lo_r;
                z_hi_r <= z_hi_r;
            end
            wide_r      <= wide_s;
            bus_out_r   <= bus_out_s;
            bus_valid_r <= bus_valid_s;
            bus_is_hi_r <= bus_is_hi_s;
            lo_we_r     <= lo_we_s;
            hi_we_r     <= hi_we_s;
            count_r     <= count_s;
        end
    end

    assign io.in_ready    = (state_r == ST_IDLE);
    assign io.bus_out     = bus_out_r;
    assign io.bus_valid   = bus_valid_r;
    assign io.bus_is_hi   = bus_is_hi_r;
    assign z_lo           = z_lo_r;
    assign z_hi           = z_hi_r;
    assign lo_we          = lo_we_r;
    assign hi_we          = hi_we_r;
    assign result_count   = count_r;

endmodule

// File: doc/alu_result_drain.md
Name: alu_result_drain

Overview:
- Consumer end of the ALU output interface: captures the 64-bit ALU result into the Z register pair (ZHI/ZLO).
- Drains the captured result onto the 32-bit datapath bus as one or two beats with a valid/ready handshake.
- Sits between the combinational ALU and the bus/register-file writeback.
- Multiply/divide results produce two beats, LO then HI; all other ops produce one LO beat.

Parameters:
- DATA_W, 32, bus word width; ALU result width is 2*DATA_W.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result present and ready for capture.
- in_ready  out  1  drain can accept a result; equals (state==IDLE).
- op_code  in  5  opcode that produced alu_out; sampled at capture.
- alu_out  in  2*DATA_W  ALU result; [DATA_W-1:0]=LO, [2*DATA_W-1:DATA_W]=HI.
- bus_out  out  DATA_W  current beat data.
- bus_valid  out  1  beat valid.
- bus_ready  in  1  bus sink accepts beat.
- bus_is_hi  out  1  current beat is the HI word.
- z_lo  out  DATA_W  captured ZLO register.
- z_hi  out  DATA_W  captured ZHI register.
- lo_we  out  1  one-cycle pulse: ZLO written.
- hi_we  out  1  one-cycle pulse: ZHI written.
- result_count  out  CNT_W  number of fully drained results.

Behaviour:
- Reset (clear=1 at a rising edge):
  - state=IDLE.
  - z_lo, z_hi, bus_out = 0.
  - bus_valid, bus_is_hi, lo_we, hi_we = 0.
  - result_count = 0.
  - clear takes priority over every other event.
- States: IDLE, LO, HI.
- Capture:
  - Occurs in IDLE when in_valid=1.
  - z_lo <= alu_out[LO]; z_hi <= alu_out[HI].
  - lo_we=1 for the next cycle only.
  - hi_we=1 for the next cycle only if the op is wide.
  - wide latch <= (op_code==5'b01110 multiply || op_code==5'b01111 divide).
  - Next state = LO.
- Latency: first beat is valid on the cycle after capture (capture edge N, bus_valid=1 during cycle N+1).
- LO state:
  - bus_out=z_lo, bus_is_hi=0, bus_valid=1.
  - On bus_ready=1: if wide, next state=HI; else next state=IDLE and result_count increments.
- HI state:
  - bus_out=z_hi, bus_is_hi=1, bus_valid=1.
  - On bus_ready=1: next state=IDLE and result_count increments.
- Backpressure: while bus_valid=1 and bus_ready=0, bus_out, bus_is_hi, state, z_lo and z_hi hold indefinitely.
- in_ready=0 in LO and HI. in_valid is ignored there, and new results do not overwrite z_lo/z_hi. Back-to-back captures therefore need at least one IDLE cycle.
- bus_ready is ignored when bus_valid=0.
- Register outputs are registered; in_ready is decoded from state.
- result_count wraps from 2^CNT_W-1 to 0.
- Every non-wide opcode (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, neg 10000, not 10001, undefined codes) is treated as single-beat. ZHI is still captured but not driven on the bus.
- Clear mid-transfer (LO or HI): the result is dropped, no further beat is emitted, result_count is not incremented, and all outputs go to reset values next cycle.
- Simultaneous in_valid with clear: clear wins and nothing is captured.

Test Plan:
- Single-beat add: clear 2 cycles; alu_out=64'd12, op=00011, in_valid 1 cycle, bus_ready=1.
  - Cycle N+1: lo_we=1, hi_we=0, bus_out=12, bus_is_hi=0.
  - Next cycle: IDLE, result_count=1.
- Multiply, two beats: alu_out=64'd20, op=01110, bus_ready=1.
  - Beat 1: LO=20, bus_is_hi=0.
  - Beat 2: HI=0, bus_is_hi=1.
  - hi_we pulses once; result_count=1.
- Negative multiply: alu_out=64'hFFFF_FFFF_FFFF_FFFA, op=01110.
  - Beats 32'hFFFF_FFFA then 32'hFFFF_FFFF.
  - z_hi=32'hFFFF_FFFF.
- Divide with backpressure: alu_out={HI=32'd0 rem, LO=32'd5 quot}, op=01111, bus_ready=0 for 4 cycles then 1.
  - bus_out=5 is held stable 5 cycles, then the HI beat 0 follows.
  - in_valid pulses during the hold with alu_out=64'd99 are ignored; z_lo stays 5.
- Clear mid-HI: start multiply, assert clear while in HI with bus_ready=0.
  - Next cycle: bus_valid=0, state IDLE, z_lo=z_hi=0, result_count=0.
- Not op: alu_out={32'h1234, 32'hFFFF_FFF5}, op=10001.
  - One beat 32'hFFFF_FFF5 only.
  - z_hi=32'h1234 captured; hi_we=0.
